// File: rtl/reg8_rr_arbiter.sv
// Round-robin arbiter in front of one shared WIDTH-bit register.
// A requester holding lock keeps ownership for up to MAX_HOLD back-to-back writes.
module reg8_rr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         lock,
    input  logic [N_REQ*WIDTH-1:0]   d,
    output logic [N_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]         q,
    output logic [$clog2(N_REQ)-1:0] q_src,
    output logic                     q_upd,
    output logic                     busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   ptr;
    logic [HW-1:0]   hold_cnt;

    logic [IW-1:0]   arb_ptr;
    logic            keep;
    logic            win_found;
    logic [IW-1:0]   win;
    logic            wr_en;
    logic [IW-1:0]   wr_src;
    logic [WIDTH-1:0] wr_data;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (int'(i) == N_REQ - 1) return '0;
        return i + IW'(1);
    endfunction

    // On release the search starts just past the owner, so arbitration
    // runs on the same edge without a bubble cycle.
    always_comb begin
        int idx;
        idx       = 0;
        arb_ptr   = (state == OWN) ? next_idx(owner) : ptr;
        keep      = (state == OWN) && req[owner] && lock[owner] &&
                    (hold_cnt < HW'(MAX_HOLD));
        win_found = 1'b0;
        win       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(arb_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win       = IW'(idx);
            end
        end
        wr_en   = keep || win_found;
        wr_src  = keep ? owner : win;
        wr_data = d[int'(wr_src)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            q        <= '0;
            q_src    <= '0;
            gnt      <= '0;
            q_upd    <= 1'b0;
        end else begin
            q_upd <= wr_en;
            gnt   <= wr_en ? (N_REQ'(1) << wr_src) : '0;
            if (wr_en) begin
                q     <= wr_data;
                q_src <= wr_src;
            end
            if (keep) begin
                hold_cnt <= hold_cnt + HW'(1);
            end else begin
                state    <= IDLE;
                hold_cnt <= '0;
                ptr      <= arb_ptr;
                if (win_found) begin
                    if (lock[win] && MAX_HOLD > 1) begin
                        state    <= OWN;
                        owner    <= win;
                        hold_cnt <= HW'(1);
                    end else begin
                        ptr <= next_idx(win);
                    end
                end
            end
        end
    end

    assign busy = (state == OWN);

endmodule

// File: tb/tb_reg8_rr_arbiter.sv
// Self-checking bench for reg8_rr_arbiter: vector table, hand-written burst/reset
// sequences, and randomized traffic against a behavioural model.
module tb_reg8_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] d;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [1:0]     q_src;
    logic           q_upd;
    logic           busy;

    int checks = 0;
    int errors = 0;

    reg8_rr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .d(d),
        .gnt(gnt), .q(q), .q_src(q_src), .q_upd(q_upd), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] d;
        logic [7:0]  q;
        logic [3:0]  gnt;
        logic [1:0]  src;
        logic        upd;
        logic        busy;
    } vec_t;

    vec_t tbl[7];

    // behavioural model state
    int          m_owner;
    int          m_cnt;
    int          m_ptr;
    logic [7:0]  e_q;
    logic [3:0]  e_gnt;
    logic [1:0]  e_src;
    logic        e_upd;
    logic        e_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] xq, input logic [3:0] xg,
                             input logic [1:0] xs, input logic xu, input logic xb);
        check({tag, ".q"}, 32'(q), 32'(xq));
        check({tag, ".gnt"}, 32'(gnt), 32'(xg));
        check({tag, ".q_src"}, 32'(q_src), 32'(xs));
        check({tag, ".q_upd"}, 32'(q_upd), 32'(xu));
        check({tag, ".busy"}, 32'(busy), 32'(xb));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        step();
        reset = 1'b0;
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        e_q     = '0;
        e_src   = '0;
    endtask

    function automatic logic [7:0] dsel(input logic [31:0] dv, input int i);
        return dv[i*8 +: 8];
    endfunction

    // Predict outputs after the coming edge from the arbitration rules.
    task automatic model_edge();
        int w;
        e_gnt = '0;
        e_upd = 1'b0;
        if (m_owner >= 0 && req[m_owner] && lock[m_owner] && m_cnt < MH) begin
            e_q   = dsel(d, m_owner);
            e_src = 2'(m_owner);
            e_gnt = 4'(1 << m_owner);
            e_upd = 1'b1;
            m_cnt = m_cnt + 1;
        end else begin
            if (m_owner >= 0) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_cnt   = 0;
            end
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) begin
                e_q   = dsel(d, w);
                e_src = 2'(w);
                e_gnt = 4'(1 << w);
                e_upd = 1'b1;
                if (lock[w] && MH > 1) begin
                    m_owner = w;
                    m_cnt   = 1;
                end else begin
                    m_ptr = (w + 1) % N;
                end
            end
        end
        e_busy = (m_owner >= 0);
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        d     = '0;

        tbl[0] = '{1'b1, 4'b0100, 4'b0000, 32'h0009_0000, 8'h09, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 4'b0000, 4'b0000, 32'h0009_0000, 8'h09, 4'b0000, 2'd2, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 4'b1111, 4'b0000, 32'h4433_2211, 8'h11, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 4'b1111, 4'b0000, 32'h4433_2211, 8'h22, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 4'b1111, 4'b0000, 32'h4433_2211, 8'h33, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 4'b1111, 4'b0000, 32'h4433_2211, 8'h44, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 4'b1111, 4'b0000, 32'h4433_2211, 8'h11, 4'b0001, 2'd0, 1'b1, 1'b0};

        // reset held with every requester active: nothing may be written
        req = 4'b1111;
        d   = 32'h4433_2211;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst.q", 32'(q), 32'h0);
            check("rst.gnt", 32'(gnt), 32'h0);
            check("rst.q_upd", 32'(q_upd), 32'h0);
            check("rst.busy", 32'(busy), 32'h0);
        end
        reset = 1'b0;
        step();
        check_all("rst_release", 8'h11, 4'b0001, 2'd0, 1'b1, 1'b0);

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].rst) do_reset();
            req  = tbl[i].req;
            lock = tbl[i].lock;
            d    = tbl[i].d;
            step();
            check_all($sformatf("tbl%0d", i), tbl[i].q, tbl[i].gnt, tbl[i].src, tbl[i].upd, tbl[i].busy);
        end

        // full locked burst by requester 1, then release to 3 and 0
        do_reset();
        d    = 32'hD3D2_A1D0;
        req  = 4'b0010;
        lock = 4'b0010;
        step();
        check_all("burst.w1", 8'hA1, 4'b0010, 2'd1, 1'b1, 1'b1);
        req = 4'b1011;
        for (int i = 2; i <= 4; i++) begin
            d[15:8] = 8'(8'hA0 + i);
            step();
            check_all($sformatf("burst.w%0d", i), 8'(8'hA0 + i), 4'b0010, 2'd1, 1'b1, 1'b1);
        end
        d[15:8] = 8'hA5;
        step();
        check_all("burst.rel3", 8'hD3, 4'b1000, 2'd3, 1'b1, 1'b0);
        step();
        check_all("burst.then0", 8'hD0, 4'b0001, 2'd0, 1'b1, 1'b0);

        // lock dropped after two writes: release without a bubble
        do_reset();
        d    = 32'hD3D2_A1D0;
        req  = 4'b0010;
        lock = 4'b0010;
        step();
        req = 4'b1011;
        step();
        check_all("drop.w2", 8'hA1, 4'b0010, 2'd1, 1'b1, 1'b1);
        lock = 4'b0000;
        step();
        check_all("drop.rel3", 8'hD3, 4'b1000, 2'd3, 1'b1, 1'b0);

        // asynchronous reset in the middle of a burst
        do_reset();
        d    = 32'hD3D2_A1D0;
        req  = 4'b0010;
        lock = 4'b0010;
        step();
        step();
        check("midrst.busy_before", 32'(busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        check_all("midrst.async", 8'h00, 4'b0000, 2'd0, 1'b0, 1'b0);
        req  = 4'b0101;
        lock = 4'b0000;
        step();
        check_all("midrst.held", 8'h00, 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        check_all("midrst.first", 8'hD0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step();
        check_all("midrst.second", 8'hD2, 4'b0100, 2'd2, 1'b1, 1'b0);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                req[i]  = ($urandom_range(0, 9) < 6);
                lock[i] = ($urandom_range(0, 9) < 5);
            end
            d = $urandom;
            model_edge();
            step();
            check_all($sformatf("rand%0d", c), e_q, e_gnt, e_src, e_upd, e_busy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
